// File: rtl/call_stack_pkg.sv
// Shared command encodings and call-frame layout for the call_stack LIFO.
package call_stack_pkg;

   localparam logic [1:0] CMD_IDLE = 2'b00;
   localparam logic [1:0] CMD_PUSH = 2'b01;
   localparam logic [1:0] CMD_POP  = 2'b10;
   localparam logic [1:0] CMD_REPL = 2'b11;

   localparam int unsigned FRAME_W = 32;

   // Layout of one frame at the default 32-bit width, MSB first.
   typedef struct packed {
      logic [3:0]  arg;
      logic [15:0] acc;
      logic [11:0] tag;
   } frame_t;

endpackage

// File: rtl/call_stack_stack_mem.sv
// DEPTH x WIDTH frame storage: synchronous write, asynchronous read, no reset.
module stack_mem #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/call_stack.sv
// Call-frame LIFO for the recursion engine; popped frames return registered with a valid strobe.
// Optional high-water-mark tracking is enabled by defining CALL_STACK_HWM_EN.
module call_stack
   import call_stack_pkg::*;
#(
   parameter  int WIDTH = 32,
   parameter  int DEPTH = 16,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       r_w,
   input  logic [WIDTH-1:0] push,
   output logic [WIDTH-1:0] pop,
   output logic             pop_valid,
   output logic [WIDTH-1:0] top,
   output logic [AW:0]      count,
   output logic             empty,
   output logic             full,
   output logic             err,
   output logic [AW:0]      hwm
);

   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [AW:0]      count_q, count_nx;
   logic [WIDTH-1:0] pop_q, pop_nx;
   logic             pv_q, pv_nx;
   logic             err_q, err_nx;
   logic             wr_en;
   logic [AW-1:0]    wr_addr, top_addr;
   logic [WIDTH-1:0] rd_data;

   // Wraps to DEPTH-1 when full, which is exactly the top slot.
   assign top_addr = count_q[AW-1:0] - 1'b1;

   stack_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk   (clk),
      .we    (wr_en),
      .waddr (wr_addr),
      .wdata (push),
      .raddr (top_addr),
      .rdata (rd_data)
   );

   assign empty = (count_q == '0);
   assign full  = (count_q == FULL_CNT);

   always_comb begin
      wr_en    = 1'b0;
      wr_addr  = count_q[AW-1:0];
      count_nx = count_q;
      pop_nx   = pop_q;
      pv_nx    = 1'b0;
      err_nx   = err_q;
      case (r_w)
         CMD_PUSH: begin
            if (!full) begin
               wr_en    = 1'b1;
               count_nx = count_q + 1'b1;
            end else begin
               err_nx = 1'b1;
            end
         end
         CMD_POP: begin
            if (!empty) begin
               pop_nx   = rd_data;
               pv_nx    = 1'b1;
               count_nx = count_q - 1'b1;
            end else begin
               pop_nx = '0;
               err_nx = 1'b1;
            end
         end
         CMD_REPL: begin
            wr_en = 1'b1;
            if (!empty) begin
               pop_nx  = rd_data;
               pv_nx   = 1'b1;
               wr_addr = top_addr;
            end else begin
               // Underflow still performs the push into slot 0.
               err_nx   = 1'b1;
               wr_addr  = '0;
               count_nx = (AW+1)'(1);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
         pop_q   <= '0;
         pv_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         count_q <= count_nx;
         pop_q   <= pop_nx;
         pv_q    <= pv_nx;
         err_q   <= err_nx;
      end
   end

   assign count     = count_q;
   assign pop       = pop_q;
   assign pop_valid = pv_q;
   assign err       = err_q;
   assign top       = empty ? '0 : rd_data;

`ifdef CALL_STACK_HWM_EN
   logic [AW:0] hwm_q;

   always_ff @(posedge clk) begin
      if (rst)                   hwm_q <= '0;
      else if (count_nx > hwm_q) hwm_q <= count_nx;
   end

   assign hwm = hwm_q;
`else
   assign hwm = '0;
`endif

endmodule

// File: tb/tb_call_stack.sv
// Self-checking bench for call_stack: directed vector table plus full/overflow and high-water sequences.
module tb_call_stack;

   localparam int WIDTH = 32;
   localparam int DEPTH = 16;
   localparam int AW    = $clog2(DEPTH);

   logic             clk = 1'b0;
   logic             rst;
   logic [1:0]       r_w;
   logic [WIDTH-1:0] push;
   logic [WIDTH-1:0] pop;
   logic             pop_valid;
   logic [WIDTH-1:0] top;
   logic [AW:0]      count;
   logic             empty;
   logic             full;
   logic             err;
   logic [AW:0]      hwm;

   int unsigned n_pass  = 0;
   int unsigned n_total = 0;
   int unsigned hwm_m   = 0;

   always #5 clk = ~clk;

   call_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .r_w       (r_w),
      .push      (push),
      .pop       (pop),
      .pop_valid (pop_valid),
      .top       (top),
      .count     (count),
      .empty     (empty),
      .full      (full),
      .err       (err),
      .hwm       (hwm)
   );

   typedef struct {
      logic        rst;
      logic [1:0]  rw;
      logic [31:0] din;
      logic        chk_pop;
      logic [31:0] exp_pop;
      logic        exp_pv;
      int unsigned exp_cnt;
      logic [31:0] exp_top;
      logic        exp_err;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r, input logic [1:0] rw, input logic [31:0] d,
                      input logic cp, input logic [31:0] ep, input logic epv,
                      input int unsigned ec, input logic [31:0] et, input logic ee);
      vec_t v;
      v = '{rst:r, rw:rw, din:d, chk_pop:cp, exp_pop:ep, exp_pv:epv,
            exp_cnt:ec, exp_top:et, exp_err:ee};
      vecs.push_back(v);
   endtask

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic step(input logic r, input logic [1:0] rw, input logic [31:0] d);
      rst  = r;
      r_w  = rw;
      push = d;
      @(posedge clk);
      #1;
      if (r) hwm_m = 0;
   endtask

   task automatic check(input string tag, input logic cp, input logic [31:0] ep,
                        input logic epv, input int unsigned ec, input logic [31:0] et,
                        input logic ee);
      if (ec > hwm_m) hwm_m = ec;
      if (cp) cmp({tag, ".pop"}, pop, ep);
      cmp({tag, ".pop_valid"}, 32'(pop_valid), 32'(epv));
      cmp({tag, ".count"}, 32'(count), ec);
      cmp({tag, ".top"}, top, et);
      cmp({tag, ".empty"}, 32'(empty), 32'(ec == 0));
      cmp({tag, ".full"}, 32'(full), 32'(ec == DEPTH));
      cmp({tag, ".err"}, 32'(err), 32'(ee));
`ifdef CALL_STACK_HWM_EN
      cmp({tag, ".hwm"}, 32'(hwm), hwm_m);
`else
      cmp({tag, ".hwm"}, 32'(hwm), 0);
`endif
   endtask

   initial begin
      rst  = 1'b1;
      r_w  = 2'b00;
      push = '0;

      // Basic LIFO order and pop hold on idle
      add(1, 2'b00, 32'h00, 1, 32'h00, 0, 0, 32'h00, 0);
      add(0, 2'b01, 32'h11, 1, 32'h00, 0, 1, 32'h11, 0);
      add(0, 2'b01, 32'h22, 1, 32'h00, 0, 2, 32'h22, 0);
      add(0, 2'b01, 32'h33, 1, 32'h00, 0, 3, 32'h33, 0);
      add(0, 2'b10, 32'h00, 1, 32'h33, 1, 2, 32'h22, 0);
      add(0, 2'b10, 32'h00, 1, 32'h22, 1, 1, 32'h11, 0);
      add(0, 2'b10, 32'h00, 1, 32'h11, 1, 0, 32'h00, 0);
      add(0, 2'b00, 32'h00, 1, 32'h11, 0, 0, 32'h00, 0);
      // Underflow on pop, sticky err across legal traffic
      add(1, 2'b00, 32'h00, 1, 32'h00, 0, 0, 32'h00, 0);
      add(0, 2'b10, 32'h00, 1, 32'h00, 0, 0, 32'h00, 1);
      add(0, 2'b01, 32'h44, 1, 32'h00, 0, 1, 32'h44, 1);
      add(0, 2'b10, 32'h00, 1, 32'h44, 1, 0, 32'h00, 1);
      // Replace-top, then replace on empty
      add(1, 2'b00, 32'h00, 1, 32'h00, 0, 0, 32'h00, 0);
      add(0, 2'b01, 32'h05, 1, 32'h00, 0, 1, 32'h05, 0);
      add(0, 2'b11, 32'h09, 1, 32'h05, 1, 1, 32'h09, 0);
      add(0, 2'b10, 32'h00, 1, 32'h09, 1, 0, 32'h00, 0);
      add(0, 2'b11, 32'h77, 0, 32'h00, 0, 1, 32'h77, 1);
      // Reset overrides a concurrent push
      add(0, 2'b01, 32'h88, 0, 32'h00, 0, 2, 32'h88, 1);
      add(1, 2'b01, 32'hEE, 1, 32'h00, 0, 0, 32'h00, 0);
      add(0, 2'b10, 32'h00, 1, 32'h00, 0, 0, 32'h00, 1);

      foreach (vecs[i]) begin
         step(vecs[i].rst, vecs[i].rw, vecs[i].din);
         check($sformatf("v%0d", i), vecs[i].chk_pop, vecs[i].exp_pop, vecs[i].exp_pv,
               vecs[i].exp_cnt, vecs[i].exp_top, vecs[i].exp_err);
      end

      // Fill to DEPTH, overflow, replace while full, drain
      step(1, 2'b00, 0);
      check("fill.rst", 1, 0, 0, 0, 0, 0);
      for (int i = 0; i < DEPTH; i++) begin
         step(0, 2'b01, 32'(i));
         check($sformatf("fill%0d", i), 0, 0, 0, i + 1, 32'(i), 0);
      end
      step(0, 2'b01, 32'hAA);
      check("ovf", 0, 0, 0, DEPTH, 32'(DEPTH - 1), 1);
      step(0, 2'b11, 32'hBB);
      check("repl_full", 1, 32'(DEPTH - 1), 1, DEPTH, 32'hBB, 1);
      step(0, 2'b10, 0);
      check("pop_full", 1, 32'hBB, 1, DEPTH - 1, 32'(DEPTH - 2), 1);
      for (int i = DEPTH - 2; i >= 0; i--) begin
         step(0, 2'b10, 0);
         check($sformatf("drain%0d", i), 1, 32'(i), 1, i, (i == 0) ? 32'h0 : 32'(i - 1), 1);
      end

      // High-water mark: push 5, pop 3, push 1
      step(1, 2'b00, 0);
      check("hwm.rst", 1, 0, 0, 0, 0, 0);
      for (int i = 1; i <= 5; i++) begin
         step(0, 2'b01, 32'(i * 16));
         check($sformatf("hwm.push%0d", i), 1, 0, 0, i, 32'(i * 16), 0);
      end
      for (int i = 5; i >= 3; i--) begin
         step(0, 2'b10, 0);
         check($sformatf("hwm.pop%0d", i), 1, 32'(i * 16), 1, i - 1, 32'((i - 1) * 16), 0);
      end
      step(0, 2'b01, 32'h123);
      check("hwm.repush", 1, 32'h30, 0, 3, 32'h123, 0);
`ifdef CALL_STACK_HWM_EN
      cmp("hwm.final", 32'(hwm), 5);
`else
      cmp("hwm.final", 32'(hwm), 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
